jesd204b_descrambler: RTL and testbench

Receive-side self-synchronous descrambler for JESD204B, polynomial 1 + x^14 + x^15. It is the inverse of the transmitter scrambler: it recovers the user octets from the scrambled lane data after 8b/10b decode and lane alignment, before the transport-layer deframer. One registered stage with a valid qualifier, a bypass mode, and a lock indicator that reports when the 15-bit state has been filled with received data.

---
 rtl/jesd204b_descrambler.sv | 72 +++++++
 tb/tb_jesd204b_descrambler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_descrambler.sv
// JESD204B receive descrambler, polynomial 1 + x^14 + x^15, self-synchronous.
// One registered stage with valid qualifier, bypass, synchronous restart and lock flag.
module jesd204b_descrambler #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  locked
);

    localparam logic [14:0] SEED = 15'h7F80;
    localparam int          STEP = (DATA_WIDTH > 15) ? 15 : DATA_WIDTH;

    logic [14:0]            s;
    logic [3:0]             cnt;
    logic [DATA_WIDTH+14:0] ext;
    logic [DATA_WIDTH-1:0]  dscr;
    logic [4:0]             cnt_sum;
    logic [3:0]             cnt_next;

    // History of received bits, oldest state bit at the top; each output bit
    // only needs the two received bits 14 and 15 positions earlier.
    assign ext = {s, in};

    always_comb begin
        dscr = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            dscr[i] = in[i] ^ ext[i+15] ^ ext[i+14];
        end
    end

    always_comb begin
        cnt_sum  = {1'b0, cnt} + 5'(STEP);
        cnt_next = (cnt_sum > 5'd15) ? 4'd15 : cnt_sum[3:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s         <= SEED;
            cnt       <= 4'd0;
            locked    <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            s         <= SEED;
            cnt       <= 4'd0;
            locked    <= 1'b0;
            out_valid <= 1'b0;
        end else if (!en) begin
            // Bypass keeps the state so descrambling can resume from it later.
            out       <= in;
            out_valid <= in_valid;
            cnt       <= 4'd0;
            locked    <= 1'b0;
        end else if (in_valid) begin
            out       <= dscr;
            out_valid <= 1'b1;
            s         <= ext[14:0];
            cnt       <= cnt_next;
            locked    <= (cnt_next == 4'd15);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jesd204b_descrambler.sv
// Directed bench for jesd204b_descrambler at widths 8 and 128 with a bit-serial
// transmit scrambler model providing the expected data.
module tb_jesd204b_descrambler;

    localparam logic [14:0] SEED = 15'h7F80;

    logic         clk;
    logic         reset;
    logic         en8, clr8, v8;
    logic [7:0]   in8;
    logic         ov8, lk8;
    logic [7:0]   out8;
    logic         en128, clr128, v128;
    logic [127:0] in128;
    logic         ov128, lk128;
    logic [127:0] out128;

    int checks;
    int failures;

    jesd204b_descrambler #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en8), .clr(clr8), .in_valid(v8), .in(in8),
        .out_valid(ov8), .out(out8), .locked(lk8)
    );

    jesd204b_descrambler #(.DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .reset(reset), .en(en128), .clr(clr128), .in_valid(v128), .in(in128),
        .out_valid(ov128), .out(out128), .locked(lk128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transmitter: scrambled bit = data ^ s14 ^ s13, scrambled bit shifted in.
    function automatic logic [127:0] tx_scr(input logic [127:0] d, input int w,
                                            input logic [14:0] si, output logic [14:0] so);
        logic [14:0]  s;
        logic [127:0] r;
        logic         b;
        s = si;
        r = '0;
        for (int i = w - 1; i >= 0; i--) begin
            b    = d[i] ^ s[14] ^ s[13];
            r[i] = b;
            s    = {s[13:0], b};
        end
        so = s;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [14:0]  tx_s;
    logic [14:0]  tx_s8;
    logic [127:0] data, last_data, pattern;
    logic [7:0]   d8;
    int           nvalid;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        en8 = 1'b1; clr8 = 1'b0; v8 = 1'b0; in8 = '0;
        en128 = 1'b1; clr128 = 1'b0; v128 = 1'b0; in128 = '0;
        repeat (3) tick();
        chk("rst_out8", {120'd0, out8}, 128'd0);
        chk("rst_ov8", {127'd0, ov8}, 128'd0);
        chk("rst_lk8", {127'd0, lk8}, 128'd0);
        chk("rst_out128", out128, 128'd0);
        chk("rst_lk128", {127'd0, lk128}, 128'd0);
        reset = 1'b1;
        tick();

        // Hand-computed vectors against the seed, width 8
        in8 = 8'h01; v8 = 1'b1;
        tick();
        chk("seed_b1_out", {120'd0, out8}, 128'h00);
        chk("seed_b1_ov", {127'd0, ov8}, 128'd1);
        chk("seed_b1_lk", {127'd0, lk8}, 128'd0);
        in8 = 8'h00;
        tick();
        chk("seed_b2_out", {120'd0, out8}, 128'h00);
        chk("seed_b2_lk", {127'd0, lk8}, 128'd1);
        in8 = 8'hFF;
        tick();
        chk("seed_b3_out", {120'd0, out8}, 128'hF9);
        v8 = 1'b0; in8 = 8'h5A;
        tick();
        chk("gap8_ov", {127'd0, ov8}, 128'd0);
        chk("gap8_hold", {120'd0, out8}, 128'hF9);
        chk("gap8_lk", {127'd0, lk8}, 128'd1);

        // Loopback width 128; second half with ~30% idle cycles
        tx_s = SEED;
        nvalid = 0;
        last_data = '0;
        for (int b = 0; b < 1000; b++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            if (b >= 500 && $urandom_range(99) < 30) begin
                v128 = 1'b0;
                in128 = data;
                tick();
                chk("lb_gap_ov", {127'd0, ov128}, 128'd0);
                chk("lb_gap_hold", out128, last_data);
            end else begin
                v128 = 1'b1;
                in128 = tx_scr(data, 128, tx_s, tx_s);
                tick();
                chk("lb_ov", {127'd0, ov128}, 128'd1);
                chk("lb_data", out128, data);
                if (nvalid > 0) chk("lb_lk", {127'd0, lk128}, 128'd1);
                nvalid++;
                last_data = data;
            end
        end

        // Bypass, then clr, then a beat against the seed
        pattern = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        en128 = 1'b0; v128 = 1'b1; in128 = pattern;
        tick();
        chk("byp_out", out128, pattern);
        chk("byp_ov", {127'd0, ov128}, 128'd1);
        chk("byp_lk", {127'd0, lk128}, 128'd0);
        clr128 = 1'b1; en128 = 1'b1; in128 = ~pattern;
        tick();
        chk("clr_ov", {127'd0, ov128}, 128'd0);
        chk("clr_hold", out128, pattern);
        chk("clr_lk", {127'd0, lk128}, 128'd0);
        clr128 = 1'b0;
        tx_s = SEED;
        data = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        in128 = tx_scr(data, 128, tx_s, tx_s);
        tick();
        chk("post_clr_data", out128, data);
        chk("post_clr_lk", {127'd0, lk128}, 128'd1);

        // Self-sync, width 8: transmitter runs 37 beats before the receiver starts
        tx_s8 = SEED;
        for (int b = 0; b < 37; b++) begin
            d8 = 8'($urandom);
            void'(tx_scr({120'd0, d8}, 8, tx_s8, tx_s8));
        end
        clr8 = 1'b1; v8 = 1'b0;
        tick();
        chk("ss_clr_lk", {127'd0, lk8}, 128'd0);
        clr8 = 1'b0; v8 = 1'b1;
        for (int b = 1; b <= 20; b++) begin
            d8 = 8'($urandom);
            in8 = 8'(tx_scr({120'd0, d8}, 8, tx_s8, tx_s8));
            tick();
            if (b == 1) chk("ss_lk_b1", {127'd0, lk8}, 128'd0);
            if (b == 2) chk("ss_lk_b2", {127'd0, lk8}, 128'd1);
            if (b >= 3) chk("ss_data", {120'd0, out8}, {120'd0, d8});
        end

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out128", out128, 128'd0);
        chk("arst_ov128", {127'd0, ov128}, 128'd0);
        chk("arst_lk128", {127'd0, lk128}, 128'd0);
        chk("arst_out8", {120'd0, out8}, 128'd0);
        chk("arst_lk8", {127'd0, lk8}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
